// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe -- RV32 immediate generator with a 2-entry skid FIFO.
//
// Decodes up to LANES instruction words per beat into a format code and a
// sign-extended immediate, then buffers the decoded beat so the input side
// sees a registered ready.
//
// Parameters:
//   XLEN  : immediate width per lane (32 or 64)
//   LANES : instructions per beat (1..4)
//
// Ports:
//   clk         : clock, rising edge
//   rst_n       : synchronous active-low reset
//   in_valid    : input beat valid
//   in_ready    : input beat accepted when in_valid && in_ready (registered)
//   in_instr    : LANES x 32-bit instruction words, lane k at [32k+31:32k]
//   in_mask     : per-lane occupied flag
//   out_valid   : output beat valid
//   out_ready   : downstream accepts when out_valid && out_ready
//   out_imm     : LANES x XLEN sign-extended immediates
//   out_fmt     : LANES x 3-bit format (0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal)
//   out_mask    : in_mask of the beat at the FIFO head
//   illegal_cnt : saturating count of accepted illegal lanes
//
// Build option: define IMMGEN_ILLEGAL_CNT_EN to include the illegal-lane
// counter; otherwise illegal_cnt is tied to zero.

module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int LANES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*LANES-1:0]   in_instr,
  input  logic [LANES-1:0]      in_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN*LANES-1:0] out_imm,
  output logic [3*LANES-1:0]    out_fmt,
  output logic [LANES-1:0]      out_mask,
  output logic [15:0]           illegal_cnt
);

  localparam int EW = XLEN*LANES + 3*LANES + LANES;

  // ---------------- decode ----------------
  logic [XLEN*LANES-1:0] dec_imm;
  logic [3*LANES-1:0]    dec_fmt;
  logic [31:0]           ins;
  logic [31:0]           imm32;
  logic [2:0]            fmt;

  always_comb begin
    dec_imm = '0;
    dec_fmt = '0;
    ins     = '0;
    imm32   = '0;
    fmt     = 3'd7;
    for (int k = 0; k < LANES; k++) begin
      ins   = in_instr[32*k +: 32];
      imm32 = '0;
      fmt   = 3'd7;
      // Compressed/reserved encodings (bits[1:0] != 11) stay illegal.
      if (ins[1:0] == 2'b11) begin
        case (ins[6:0])
          7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011: begin
            fmt   = 3'd1;
            imm32 = {{20{ins[31]}}, ins[31:20]};
          end
          7'b0100011: begin
            fmt   = 3'd2;
            imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
          end
          7'b1100011: begin
            fmt   = 3'd3;
            imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
          end
          7'b0110111, 7'b0010111: begin
            fmt   = 3'd4;
            imm32 = {ins[31:12], 12'b0};
          end
          7'b1101111: begin
            fmt   = 3'd5;
            imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
          end
          7'b0110011, 7'b0111011: begin
            fmt   = 3'd0;
            imm32 = '0;
          end
          default: begin
            fmt   = 3'd7;
            imm32 = '0;
          end
        endcase
      end
      // Empty lanes carry no instruction: never illegal, never an immediate.
      if (!in_mask[k]) begin
        fmt   = 3'd0;
        imm32 = '0;
      end
      dec_imm[XLEN*k +: XLEN] = XLEN'($signed(imm32));
      dec_fmt[3*k +: 3]       = fmt;
    end
  end

  // ---------------- 2-entry skid FIFO ----------------
  logic [EW-1:0] mem [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    count;
  logic [1:0]    count_next;
  logic          push;
  logic          pop;

  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      in_ready <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {dec_imm, dec_fmt, in_mask};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count    <= count_next;
      // Registered ready reflects next cycle's starting occupancy.
      in_ready <= (count_next != 2'd2);
    end
  end

  // Entries are cleared on reset, so the head reads zero until first push.
  assign {out_imm, out_fmt, out_mask} = mem[rd_ptr];

  // ---------------- illegal-lane counter ----------------
`ifdef IMMGEN_ILLEGAL_CNT_EN
  logic [2:0]  ill_num;
  logic [16:0] cnt_sum;
  logic [15:0] cnt_q;

  always_comb begin
    ill_num = '0;
    for (int k = 0; k < LANES; k++) begin
      if (dec_fmt[3*k +: 3] == 3'd7) begin
        ill_num = ill_num + 3'd1;
      end
    end
  end

  assign cnt_sum = {1'b0, cnt_q} + {14'b0, ill_num};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (push) begin
      cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

  assign illegal_cnt = cnt_q;
`else
  assign illegal_cnt = '0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

`ifdef IMMGEN_ILLEGAL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // d0: XLEN=32, LANES=1
  logic         v0, rdy0, ov0, ordy0;
  logic [31:0]  instr0;
  logic [0:0]   mask0, om0;
  logic [31:0]  imm0;
  logic [2:0]   fmt0;
  logic [15:0]  cnt0;

  // d1: XLEN=64, LANES=2
  logic         v1, rdy1, ov1, ordy1;
  logic [63:0]  instr1;
  logic [1:0]   mask1, om1;
  logic [127:0] imm1;
  logic [5:0]   fmt1;
  logic [15:0]  cnt1;

  imm_gen_pipe #(.XLEN(32), .LANES(1)) d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .in_instr(instr0),
    .in_mask(mask0), .out_valid(ov0), .out_ready(ordy0), .out_imm(imm0),
    .out_fmt(fmt0), .out_mask(om0), .illegal_cnt(cnt0));

  imm_gen_pipe #(.XLEN(64), .LANES(2)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_instr(instr1),
    .in_mask(mask1), .out_valid(ov1), .out_ready(ordy1), .out_imm(imm1),
    .out_fmt(fmt1), .out_mask(om1), .illegal_cnt(cnt1));

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [127:0] imm;
    logic [5:0]   fmt;
    logic [1:0]   mask;
    logic [2:0]   nill;
  } exp_t;

  // Reference decode straight from the RV32I field definitions, in integers.
  function automatic void ref_decode(input logic [31:0] i, output longint v, output int f);
    v = 0;
    f = 7;
    if (i[1:0] == 2'b11) begin
      case (i[6:0])
        7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011: begin
          f = 1; v = longint'(i[31:20]);
          if (v >= 2048) v = v - 4096;
        end
        7'b0100011: begin
          f = 2; v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
          if (v >= 2048) v = v - 4096;
        end
        7'b1100011: begin
          f = 3; v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048
                   + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
          if (v >= 4096) v = v - 8192;
        end
        7'b0110111, 7'b0010111: begin
          f = 4; v = longint'(i[31:12]) * 4096;
          if (v >= 64'sh8000_0000) v = v - 64'sh1_0000_0000;
        end
        7'b1101111: begin
          f = 5; v = longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096
                   + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
          if (v >= 1048576) v = v - 2097152;
        end
        7'b0110011, 7'b0111011: begin
          f = 0; v = 0;
        end
        default: begin
          f = 7; v = 0;
        end
      endcase
    end
  endfunction

  function automatic exp_t build_exp(input logic [63:0] ins, input logic [1:0] msk,
                                     input int lanes, input int xlen);
    exp_t e;
    longint v;
    int f;
    logic [63:0] vb;
    e = '0;
    for (int k = 0; k < lanes; k++) begin
      if (msk[k]) begin
        ref_decode(ins[32*k +: 32], v, f);
      end else begin
        v = 0; f = 0;
      end
      vb = v;
      if (xlen == 32) e.imm[32*k +: 32] = vb[31:0];
      else            e.imm[64*k +: 64] = vb;
      e.fmt[3*k +: 3] = 3'(f);
      e.mask[k] = msk[k];
      if (f == 7) e.nill = e.nill + 3'd1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12];
    logic [31:0] r;
    int sel;
    ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0111011};
    r = $urandom;
    sel = $urandom_range(0, 7);
    if (sel < 6) r[6:0] = ops[$urandom_range(0, 11)];
    return r;
  endfunction

  task automatic idle_inputs();
    v0 = 0; instr0 = '0; mask0 = '0; ordy0 = 0;
    v1 = 0; instr1 = '0; mask1 = '0; ordy1 = 0;
  endtask

  // Ends at a negedge with reset released for one edge.
  task automatic reset_pulse();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL reset_in_ready0 got %b want 0", rdy0); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid0 got %b want 0", ov0); end
    checks++; if ({imm0, fmt0, om0} !== '0) begin errors++; $display("FAIL reset_outputs0 got %h want 0", {imm0, fmt0, om0}); end
    checks++; if (cnt0 !== 16'h0) begin errors++; $display("FAIL reset_cnt0 got %h want 0", cnt0); end
    checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL reset_in_ready1 got %b want 0", rdy1); end
    rst_n = 1;
    @(negedge clk);
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL release_in_ready0 got %b want 1", rdy0); end
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL release_in_ready1 got %b want 1", rdy1); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL release_out_valid0 got %b want 0", ov0); end
  endtask

  task automatic test_reset_full();
    reset_pulse();
    ordy0 = 0; v0 = 1; instr0 = 32'h0; mask0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    v0 = 0;
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", rdy0); end
    checks++; if (cnt0 !== (CNT_EN ? 16'd2 : 16'd0)) begin errors++; $display("FAIL full_cnt got %h want %h", cnt0, (CNT_EN ? 16'd2 : 16'd0)); end
    checks++; if (fmt0 !== 3'd7) begin errors++; $display("FAIL full_fmt got %0d want 7", fmt0); end
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL rstfull_out_valid got %b want 0", ov0); end
    checks++; if (cnt0 !== 16'h0) begin errors++; $display("FAIL rstfull_cnt got %h want 0", cnt0); end
    @(negedge clk);
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL rstfull_in_ready got %b want 1", rdy0); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL rstfull_out_valid2 got %b want 0", ov0); end
  endtask

  task automatic test_directed_32();
    reset_pulse();
    ordy0 = 0; v0 = 1; instr0 = 32'hFFF00093; mask0 = 1'b1;
    @(negedge clk);
    v0 = 0;
    checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL i_latency got %b want 1", ov0); end
    checks++; if (imm0 !== 32'hFFFFFFFF) begin errors++; $display("FAIL i_imm got %h want ffffffff", imm0); end
    checks++; if (fmt0 !== 3'd1) begin errors++; $display("FAIL i_fmt got %0d want 1", fmt0); end
    ordy0 = 1;
    @(negedge clk);
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL i_drain got %b want 0", ov0); end
    v0 = 1; instr0 = 32'hFE000EE3;
    @(negedge clk);
    v0 = 0; ordy0 = 0;
    checks++; if (imm0 !== 32'hFFFFFFFC) begin errors++; $display("FAIL b_imm got %h want fffffffc", imm0); end
    checks++; if (fmt0 !== 3'd3) begin errors++; $display("FAIL b_fmt got %0d want 3", fmt0); end
    ordy0 = 1;
    @(negedge clk);
    ordy0 = 0;
  endtask

  task automatic test_backpressure();
    reset_pulse();
    ordy0 = 0; mask0 = 1'b1;
    v0 = 1; instr0 = 32'hFFF00093;
    @(negedge clk);
    instr0 = 32'h12345037;
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL bp_ready_second got %b want 1", rdy0); end
    @(negedge clk);
    instr0 = 32'h00100093;
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL bp_ready_third got %b want 0", rdy0); end
    @(negedge clk);
    checks++; if (imm0 !== 32'hFFFFFFFF) begin errors++; $display("FAIL bp_hold_head got %h want ffffffff", imm0); end
    ordy0 = 1;
    @(negedge clk);
    checks++; if (imm0 !== 32'h12345000 || fmt0 !== 3'd4) begin errors++; $display("FAIL bp_second got %h/%0d want 12345000/4", imm0, fmt0); end
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL bp_ready_reopen got %b want 1", rdy0); end
    @(negedge clk);
    v0 = 0;
    checks++; if (imm0 !== 32'h00000001 || fmt0 !== 3'd1) begin errors++; $display("FAIL bp_third got %h/%0d want 1/1", imm0, fmt0); end
    @(negedge clk);
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", ov0); end
    ordy0 = 0;
  endtask

  task automatic test_two_lane();
    reset_pulse();
    ordy1 = 1;
    v1 = 1; instr1 = {32'h12345037, 32'h00000000}; mask1 = 2'b11;
    @(negedge clk);
    instr1 = {32'hFFFFFFFF, 32'h8000006F}; mask1 = 2'b01;
    checks++; if (fmt1 !== {3'd4, 3'd7}) begin errors++; $display("FAIL two_fmt got %h want %h", fmt1, {3'd4, 3'd7}); end
    checks++; if (imm1 !== {64'h12345000, 64'h0}) begin errors++; $display("FAIL two_imm got %h want %h", imm1, {64'h12345000, 64'h0}); end
    checks++; if (cnt1 !== (CNT_EN ? 16'd1 : 16'd0)) begin errors++; $display("FAIL two_cnt got %h want %h", cnt1, (CNT_EN ? 16'd1 : 16'd0)); end
    @(negedge clk);
    v1 = 0;
    checks++; if (imm1 !== {64'h0, 64'hFFFFFFFFFFF00000}) begin errors++; $display("FAIL j64_imm got %h want %h", imm1, {64'h0, 64'hFFFFFFFFFFF00000}); end
    checks++; if (fmt1 !== {3'd0, 3'd5} || om1 !== 2'b01) begin errors++; $display("FAIL j64_fmt got %h/%b want %h/01", fmt1, om1, {3'd0, 3'd5}); end
    checks++; if (cnt1 !== (CNT_EN ? 16'd1 : 16'd0)) begin errors++; $display("FAIL masked_cnt got %h want %h", cnt1, (CNT_EN ? 16'd1 : 16'd0)); end
    @(negedge clk);
    ordy1 = 0;
  endtask

  task automatic test_saturation();
    reset_pulse();
    ordy1 = 1; v1 = 1; instr1 = 64'h0; mask1 = 2'b11;
    for (int i = 1; i <= 70000; i++) begin
      @(negedge clk);
      if (i == 32767) begin
        checks++; if (cnt1 !== (CNT_EN ? 16'hFFFE : 16'h0)) begin errors++; $display("FAIL sat_near got %h want %h", cnt1, (CNT_EN ? 16'hFFFE : 16'h0)); end
      end
    end
    v1 = 0;
    checks++; if (cnt1 !== (CNT_EN ? 16'hFFFF : 16'h0)) begin errors++; $display("FAIL sat_final got %h want %h", cnt1, (CNT_EN ? 16'hFFFF : 16'h0)); end
    checks++; if (fmt1 !== 6'o77) begin errors++; $display("FAIL sat_fmt got %h want 3f", fmt1); end
    @(negedge clk);
    ordy1 = 0;
  endtask

  task automatic test_random(input int which, input int n);
    exp_t q[$];
    exp_t e;
    int cnt_m;
    int lanes, xlen;
    logic [63:0] ins;
    logic [1:0] msk;
    logic vin, ordy, acc;
    logic a_rdy, a_ov;
    logic [127:0] a_imm;
    logic [5:0] a_fmt;
    logic [1:0] a_mask;
    logic [15:0] a_cnt;
    lanes = (which == 0) ? 1 : 2;
    xlen  = (which == 0) ? 32 : 64;
    reset_pulse();
    cnt_m = 0;
    for (int i = 0; i < n; i++) begin
      if (which == 0) begin
        a_rdy = rdy0; a_ov = ov0; a_imm = {96'b0, imm0}; a_fmt = {3'b0, fmt0};
        a_mask = {1'b0, om0}; a_cnt = cnt0;
      end else begin
        a_rdy = rdy1; a_ov = ov1; a_imm = imm1; a_fmt = fmt1; a_mask = om1; a_cnt = cnt1;
      end
      checks++; if (a_rdy !== (q.size() < 2)) begin errors++; $display("FAIL rnd%0d_ready cyc %0d got %b want %b", which, i, a_rdy, (q.size() < 2)); end
      checks++; if (a_ov !== (q.size() != 0)) begin errors++; $display("FAIL rnd%0d_valid cyc %0d got %b want %b", which, i, a_ov, (q.size() != 0)); end
      if (q.size() != 0) begin
        checks++;
        if (a_imm !== q[0].imm || a_fmt !== q[0].fmt || a_mask !== q[0].mask) begin
          errors++;
          $display("FAIL rnd%0d_data cyc %0d got %h/%h/%b want %h/%h/%b", which, i,
                   a_imm, a_fmt, a_mask, q[0].imm, q[0].fmt, q[0].mask);
        end
      end
      checks++; if (a_cnt !== 16'(cnt_m)) begin errors++; $display("FAIL rnd%0d_cnt cyc %0d got %h want %h", which, i, a_cnt, 16'(cnt_m)); end
      vin  = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      ins  = {rand_instr(), rand_instr()};
      msk  = 2'($urandom);
      if (lanes == 1) begin ins[63:32] = '0; msk[1] = 1'b0; end
      if (which == 0) begin
        v0 = vin; instr0 = ins[31:0]; mask0 = msk[0]; ordy0 = ordy;
      end else begin
        v1 = vin; instr1 = ins; mask1 = msk; ordy1 = ordy;
      end
      acc = vin && (q.size() < 2);
      if (ordy && q.size() != 0) void'(q.pop_front());
      if (acc) begin
        e = build_exp(ins, msk, lanes, xlen);
        q.push_back(e);
        if (CNT_EN) begin
          cnt_m = cnt_m + int'(e.nill);
          if (cnt_m > 65535) cnt_m = 65535;
        end
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_reset_full();
    test_directed_32();
    test_backpressure();
    test_two_lane();
    test_random(0, 400);
    test_random(1, 400);
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, 32: immediate output width per lane; legal values 32 or 64.
REQ-002 SHALL have parameter LANES, 1: instructions per beat; legal values 1 to 4.
REQ-003 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  in  1  input beat valid.
REQ-006 SHALL have port in_ready  out  1  input beat accepted when in_valid and in_ready are both high; driven from a register.
REQ-007 SHALL have port in_instr  in  32*LANES  RV32 instruction words; lane k occupies bits [32k+31:32k].
REQ-008 SHALL have port in_mask  in  LANES  per-lane occupied flag.
REQ-009 SHALL have port out_valid  out  1  output beat valid.
REQ-010 SHALL have port out_ready  in  1  downstream accepts the beat when out_valid and out_ready are both high.
REQ-011 SHALL have port out_imm  out  XLEN*LANES  sign-extended immediate per lane.
REQ-012 SHALL have port out_fmt  out  3*LANES  per-lane format: 0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
REQ-013 SHALL have port out_mask  out  LANES  copy of in_mask for the beat.
REQ-014 SHALL have port illegal_cnt  out  16  saturating count of illegal lanes accepted.

Function
REQ-015 SHALL decode on opcode bits[6:0]: I for 0000011, 0010011, 1100111, 0001111, 1110011; S for 0100011; B for 1100011; U for 0110111, 0010111; J for 1101111; R for 0110011 and 0111011 (imm 0).
REQ-016 SHALL build immediates per the RV32I base encoding, with B and J bit0=0 and U low 12 bits=0, and sign-extend from instr[31] to XLEN.
REQ-017 SHALL report fmt 7 and imm 0 for any other opcode, or for bits[1:0]!=2'b11.
REQ-018 SHALL force fmt 0 and imm 0 for lanes with in_mask=0; such lanes are never counted as illegal.
REQ-019 SHALL buffer decoded beats in a 2-entry skid FIFO; latency from acceptance to out_valid is 1 cycle when the FIFO is empty.
REQ-020 SHALL drive in_ready=1 when the FIFO holds fewer than 2 entries at the start of the cycle, otherwise 0.
REQ-021 SHALL deliver beats in acceptance order with no loss or duplication.
REQ-022 SHALL keep out_imm, out_fmt and out_mask stable while out_valid=1 and out_ready=0.
REQ-023 SHALL allow a push and a pop in the same cycle with 1 entry held; occupancy then stays at 1.
REQ-024 SHALL sustain one beat per cycle when out_ready is held at 1.
REQ-025 SHALL add the number of fmt-7 lanes of each accepted beat (0..LANES) to illegal_cnt, saturating at 0xFFFF.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, clear the FIFO, set out_valid=0, in_ready=0 and illegal_cnt=0.
REQ-027 SHALL drive out_imm, out_fmt and out_mask to 0 after reset until the first beat is accepted.
REQ-028 SHALL assert in_ready=1 on the first edge with rst_n=1; beats in flight when reset is applied are discarded.

Configuration
REQ-029 SHALL compile the illegal-lane counter only when the macro IMMGEN_ILLEGAL_CNT_EN is defined.
REQ-030 SHALL, without IMMGEN_ILLEGAL_CNT_EN, keep port illegal_cnt tied to 0 with no counter logic; fmt 7 reporting is unchanged.

Verification
REQ-031 SHALL cover: XLEN=32, LANES=1, in_instr=0xFFF00093 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1.
REQ-032 SHALL cover: in_instr=0xFE000EE3 -> out_imm=0xFFFFFFFC, out_fmt=3; with XLEN=64, in_instr=0x8000006F -> out_imm=0xFFFFFFFFFFF00000, out_fmt=5.
REQ-033 SHALL cover: out_ready=0 with 3 consecutive beats offered -> 2 accepted and in_ready=0 on the third; out_ready=1 -> both beats drained in order, then the third is accepted.
REQ-034 SHALL cover: LANES=2, lanes {0x00000000, 0x12345037}, mask 2'b11 -> out_fmt lane0=7, lane1=4, lane1 imm=0x12345000, illegal_cnt +1; 70000 illegal beats -> illegal_cnt=0xFFFF.
REQ-035 SHALL cover: FIFO full, rst_n low for 1 cycle -> out_valid=0, illegal_cnt=0, and in_ready=1 on the next cycle.
REQ-036 SHALL cover: build without IMMGEN_ILLEGAL_CNT_EN, illegal beats accepted -> illegal_cnt stays 0 and out_fmt=7.
